// File: rtl/macc_resp_checker_if.sv
// ---------------------------------------------------------------------------
// macc_resp_checker_if
// Stimulus/response bundle shared by a MACC and its response checker.
//   en       : a/b/carryin valid this cycle (one contiguous run per test)
//   clr      : clear the accumulator, sampled together with a/b/carryin
//   a, b     : multiplicand / multiplier seen by the MACC
//   carryin  : carry seen by the MACC
//   p        : MACC result
// Handshake: there is no back-pressure. A sample is transferred on every
// rising clock edge where en=1; p is a free-running result observed a fixed
// number of cycles after the sample that produced it.
// Modports: master drives everything (stimulus side and MACC result),
//           slave only observes (the checker).
// ---------------------------------------------------------------------------
interface macc_resp_checker_if #(
  parameter int A_W = 25,
  parameter int B_W = 18,
  parameter int P_W = 48
);
  logic           en;
  logic           clr;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           carryin;
  logic [P_W-1:0] p;

  modport master (output en, output clr, output a, output b, output carryin, output p);
  modport slave  (input  en, input  clr, input  a, input  b, input  carryin, input  p);
endinterface

// File: rtl/macc_resp_checker.sv
// ---------------------------------------------------------------------------
// macc_resp_checker
// Snoops the a/b/carryin stream feeding a MACC, keeps a bit-exact golden
// accumulator, and compares it with the MACC's p output LAT cycles later.
// Reports pass/fail, a saturating mismatch count and the first failing index.
//
// Ports:
//   clk          : clock, all state on rising edge
//   rst          : asynchronous active-high reset
//   bus_i        : slave view of macc_resp_checker_if (en, clr, a, b, carryin, p)
//   busy_o       : run in progress (FILL/CHECK/DRAIN)
//   done_o       : run finished, held until the next run starts or rst
//   fail_o       : sticky, at least one mismatch this run
//   err_count_o  : mismatches this run, saturating at all-ones
//   first_err_o  : 0-based sample index of first mismatch, 16'hFFFF if none
//   state_o      : debug view of the run state machine
//
// Build option: define MACC_CHK_SIGNED_EN to treat a and b as two's
// complement (sign-extended to P_W); otherwise they are zero-extended.
// carryin is always added unsigned.
// ---------------------------------------------------------------------------
module macc_resp_checker #(
  parameter int A_W   = 25,
  parameter int B_W   = 18,
  parameter int P_W   = 48,
  parameter int LAT   = 3,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  macc_resp_checker_if.slave   bus_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [CNT_W-1:0]     err_count_o,
  output logic [15:0]          first_err_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_CHECK = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // With LAT=1 there is nothing to fill: the first sample is compared on the
  // very next edge, so a run starts straight in CHECK.
  localparam state_t     START_ST   = (LAT > 1) ? S_FILL : S_CHECK;
  localparam logic [3:0] FILL_LAST  = (LAT > 1) ? 4'(LAT - 2) : 4'd0;
  localparam logic [3:0] DRAIN_LAST = 4'(LAT - 1);
  localparam logic [15:0] NO_ERR    = 16'hFFFF;

  state_t               state_q;
  logic [3:0]           cyc_q;
  logic                 busy_q, done_q, fail_q;
  logic [CNT_W-1:0]     err_q;
  logic [15:0]          first_q;

  logic [P_W-1:0]       acc_q, acc_d;
  logic [15:0]          idx_q;
  logic                 pipe_v_q   [LAT];
  logic [P_W-1:0]       pipe_acc_q [LAT];
  logic [15:0]          pipe_idx_q [LAT];

  logic [P_W-1:0]       a_ext, b_ext, prod, cin_ext;
  logic [15:0]          push_idx;
  logic                 start, cmp_en, mismatch;

  // ---------------- golden accumulator ----------------
  always_comb begin
`ifdef MACC_CHK_SIGNED_EN
    a_ext = {{(P_W-A_W){bus_i.a[A_W-1]}}, bus_i.a};
    b_ext = {{(P_W-B_W){bus_i.b[B_W-1]}}, bus_i.b};
`else
    a_ext = {{(P_W-A_W){1'b0}}, bus_i.a};
    b_ext = {{(P_W-B_W){1'b0}}, bus_i.b};
`endif
    // Product truncated to P_W: both signed and unsigned cases wrap mod 2^P_W.
    prod    = a_ext * b_ext;
    cin_ext = {{(P_W-1){1'b0}}, bus_i.carryin};
    acc_d   = acc_q;
    if (bus_i.en) begin
      acc_d = (bus_i.clr ? '0 : acc_q) + prod + cin_ext;
    end
  end

  // A run starts on an en edge from IDLE/DONE, or when en is already high
  // on the edge that DRAIN finishes (back-to-back runs).
  assign start = bus_i.en &&
                 ((state_q == S_IDLE) || (state_q == S_DONE) ||
                  ((state_q == S_DRAIN) && (cyc_q == DRAIN_LAST)));

  assign push_idx = start ? 16'd0 : idx_q;
  assign cmp_en   = ((state_q == S_CHECK) || (state_q == S_DRAIN)) && pipe_v_q[LAT-1];
  assign mismatch = cmp_en && (pipe_acc_q[LAT-1] != bus_i.p);

  // ---------------- delay line ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      idx_q <= 16'd0;
      for (int i = 0; i < LAT; i++) begin
        pipe_v_q[i]   <= 1'b0;
        pipe_acc_q[i] <= '0;
        pipe_idx_q[i] <= 16'd0;
      end
    end else begin
      acc_q <= acc_d;
      if (bus_i.en) begin
        idx_q <= push_idx + 16'd1;
      end
      pipe_v_q[0]   <= bus_i.en;
      pipe_acc_q[0] <= acc_d;
      pipe_idx_q[0] <= push_idx;
      for (int i = 1; i < LAT; i++) begin
        pipe_v_q[i]   <= pipe_v_q[i-1];
        pipe_acc_q[i] <= pipe_acc_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  // ---------------- run state machine and results ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      first_q <= NO_ERR;
    end else if (start) begin
      state_q <= START_ST;
      cyc_q   <= 4'd0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      first_q <= NO_ERR;
    end else begin
      if (mismatch) begin
        fail_q <= 1'b1;
        if (err_q != {CNT_W{1'b1}}) begin
          err_q <= err_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (first_q == NO_ERR) begin
          first_q <= pipe_idx_q[LAT-1];
        end
      end
      case (state_q)
        S_FILL: begin
          if (!bus_i.en) begin
            state_q <= S_DRAIN;
            cyc_q   <= 4'd0;
          end else if (cyc_q == FILL_LAST) begin
            state_q <= S_CHECK;
          end else begin
            cyc_q <= cyc_q + 4'd1;
          end
        end
        S_CHECK: begin
          if (!bus_i.en) begin
            state_q <= S_DRAIN;
            cyc_q   <= 4'd0;
          end
        end
        S_DRAIN: begin
          // The restart case is handled by start above.
          if (cyc_q == DRAIN_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign err_count_o = err_q;
  assign first_err_o = first_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_macc_resp_checker.sv
// ---------------------------------------------------------------------------
// tb_macc_resp_checker
// Drives sample runs into macc_resp_checker while acting as the MACC: the
// bench produces p from its own arithmetic model LAT cycles after each
// sample, optionally corrupting chosen samples, and checks the reported
// pass/fail, error count and first-error index.
// ---------------------------------------------------------------------------
module tb_macc_resp_checker;

  localparam int A_W   = 25;
  localparam int B_W   = 18;
  localparam int P_W   = 48;
  localparam int LAT   = 3;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  macc_resp_checker_if #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) bus ();

  logic             busy_o, done_o, fail_o;
  logic [CNT_W-1:0] err_count_o;
  logic [15:0]      first_err_o;
  logic [2:0]       state_dbg;

  macc_resp_checker #(
    .A_W(A_W), .B_W(B_W), .P_W(P_W), .LAT(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_i       (bus),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .err_count_o (err_count_o),
    .first_err_o (first_err_o),
    .state_o     (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [P_W-1:0] model_acc;
  logic [A_W-1:0] st_a[$];
  logic [B_W-1:0] st_b[$];
  bit             st_c[$];
  bit             st_clr[$];
  bit             st_bad[$];
  logic [P_W-1:0] ptab[$];     // optional hand-computed p values
  logic [P_W-1:0] exp_q[$];    // p values the MACC should present, in order

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference MACC step: plain 64-bit arithmetic, reduced mod 2^P_W.
  function automatic logic [P_W-1:0] ref_step(input logic [P_W-1:0] acc,
                                              input logic [A_W-1:0] a,
                                              input logic [B_W-1:0] b,
                                              input bit c, input bit clr);
    longint     av, bv, s;
    logic [63:0] t;
`ifdef MACC_CHK_SIGNED_EN
    av = longint'($signed(a));
    bv = longint'($signed(b));
`else
    av = longint'(a);
    bv = longint'(b);
`endif
    s = (clr ? 64'd0 : longint'(acc)) + av * bv + longint'(c);
    t = s;
    return t[P_W-1:0];
  endfunction

  function automatic logic [P_W-1:0] rnd_p();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[P_W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_stim();
    st_a.delete(); st_b.delete(); st_c.delete();
    st_clr.delete(); st_bad.delete(); ptab.delete();
  endtask

  task automatic push_sample(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                             input bit c, input bit clr, input bit bad);
    st_a.push_back(a); st_b.push_back(b); st_c.push_back(c);
    st_clr.push_back(clr); st_bad.push_back(bad);
  endtask

  task automatic push_random(input int n, input int bad_pct);
    for (int i = 0; i < n; i++) begin
      push_sample(A_W'($urandom()), B_W'($urandom()), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) < bad_pct));
    end
  endtask

  task automatic drive_idle();
    bus.en      = 1'b0;
    bus.clr     = 1'b0;
    bus.a       = A_W'($urandom());
    bus.b       = B_W'($urandom());
    bus.carryin = 1'b0;
    bus.p       = rnd_p();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"},  64'(busy_o), 64'd0);
    check_val({tag, "_done"},  64'(done_o), 64'd0);
    check_val({tag, "_fail"},  64'(fail_o), 64'd0);
    check_val({tag, "_err"},   64'(err_count_o), 64'd0);
    check_val({tag, "_first"}, 64'(first_err_o), 64'hFFFF);
  endtask

  // Enters and leaves at a falling edge. chain=1 leaves en unaffected so the
  // next run starts on the edge that this run's drain finishes.
  // abort_at>=0 asserts rst after that many sample edges.
  task automatic do_run(input string tag, input bit chain, input int abort_at);
    int n, exp_err, exp_first;
    logic [P_W-1:0] g, pv;
    n = st_a.size();
    exp_q.delete();
    exp_err = 0;
    exp_first = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      g = ref_step(model_acc, st_a[i], st_b[i], st_c[i], st_clr[i]);
      model_acc = g;
      exp_q.push_back((ptab.size() == n) ? ptab[i] : g);
      if (st_bad[i]) begin
        if (exp_err == 0) exp_first = i & 16'hFFFF;
        if (exp_err < 65535) exp_err++;
      end
    end
    for (int t = 0; t < n + LAT; t++) begin
      if (t < n) begin
        bus.en = 1'b1; bus.a = st_a[t]; bus.b = st_b[t];
        bus.carryin = st_c[t]; bus.clr = st_clr[t];
      end else begin
        bus.en = 1'b0; bus.clr = 1'b0; bus.carryin = 1'b0;
        bus.a = A_W'($urandom()); bus.b = B_W'($urandom());
      end
      if (t >= LAT) begin
        pv = exp_q.pop_front();
        if (st_bad[t-LAT]) pv = pv ^ P_W'($urandom() | 32'h1);
        bus.p = pv;
      end else begin
        bus.p = rnd_p();
      end
      @(negedge clk);
      if (t == 0) begin
        check_val({tag, "_busy_run"}, 64'(busy_o), 64'd1);
        check_val({tag, "_done_run"}, 64'(done_o), 64'd0);
      end
      if (t == abort_at) begin
        check_val({tag, "_fail_pre_rst"}, 64'(fail_o), 64'(exp_err != 0));
        rst = 1'b1;
        #1;
        check_reset_outputs({tag, "_abort"});
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        model_acc = '0;
        return;
      end
    end
    check_val({tag, "_fail"},  64'(fail_o), 64'(exp_err != 0));
    check_val({tag, "_err"},   64'(err_count_o), 64'(exp_err));
    check_val({tag, "_first"}, 64'(first_err_o), 64'(exp_first));
    if (!chain) begin
      drive_idle();
      @(negedge clk);
      check_val({tag, "_done"},      64'(done_o), 64'd1);
      check_val({tag, "_busy_end"},  64'(busy_o), 64'd0);
      check_val({tag, "_fail_held"}, 64'(fail_o), 64'(exp_err != 0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [P_W-1:0] sgn_exp;
    rst = 1'b1;
    drive_idle();
    model_acc = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    // Known sequence: 38*22+1 = 837 per sample.
    clear_stim();
    for (int i = 0; i < 5; i++) push_sample(25'd38, 18'd22, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) ptab.push_back(P_W'(837 * i));
    do_run("basic", 1'b0, -1);

    // Same sequence (restarted with clr) with sample 2 corrupted.
    clear_stim();
    for (int i = 0; i < 5; i++) push_sample(25'd38, 18'd22, 1'b1, (i == 0), (i == 2));
    for (int i = 1; i <= 5; i++) ptab.push_back(P_W'(837 * i));
    do_run("bad2", 1'b0, -1);

    // clr on sample 0 after a nonzero accumulator.
    clear_stim();
    for (int i = 0; i < 6; i++) push_sample(25'd33, 18'd12, 1'b0, (i == 0), 1'b0);
    for (int i = 1; i <= 6; i++) ptab.push_back(P_W'(396 * i));
    do_run("clr", 1'b0, -1);

    // All-ones a times 2.
`ifdef MACC_CHK_SIGNED_EN
    sgn_exp = 48'hFFFF_FFFF_FFFE;
`else
    sgn_exp = 48'd67108862;
`endif
    clear_stim();
    push_sample({A_W{1'b1}}, 18'd2, 1'b0, 1'b1, 1'b0);
    ptab.push_back(sgn_exp);
    do_run("ones", 1'b0, -1);

    // Random runs, some back-to-back, some with idle gaps.
    for (int r = 0; r < 10; r++) begin
      clear_stim();
      push_random($urandom_range(1, 24), 20);
      do_run($sformatf("rnd%0d", r), (r < 9) ? 1'($urandom_range(0, 1)) : 1'b0, -1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) begin
          drive_idle();
          @(negedge clk);
        end
      end
    end

    // Reset in the middle of CHECK with an earlier mismatch recorded.
    clear_stim();
    push_sample(25'd5, 18'd7, 1'b0, 1'b1, 1'b1);
    push_random(7, 0);
    do_run("abort", 1'b0, 3);
    clear_stim();
    push_random(9, 0);
    do_run("post_abort", 1'b0, -1);

    // Saturation: every sample wrong for 70000 samples.
    clear_stim();
    for (int i = 0; i < 70000; i++) push_sample(25'd1, 18'd1, 1'b0, (i == 0), 1'b1);
    do_run("sat", 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
